// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the memory arbiter
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   function automatic owner_t other_owner(input owner_t o);
      return (o == OWN_M0) ? OWN_M1 : OWN_M0;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - two-way round-robin grant selection
module rr_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic   i_req0,
   input  logic   i_req1,
   input  owner_t i_last,
   output logic   o_valid,
   output owner_t o_gnt
);

   assign o_valid = i_req0 | i_req1;

   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      o_gnt = OWN_M0;
      if (i_req0 && i_req1) begin
         o_gnt = other_owner(i_last);
      end else if (i_req1) begin
         o_gnt = OWN_M1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between a data master (m0) and a fetch master (m1)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_sel_i,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic                m0_ack_o,
   output logic                m0_err_o,
   input  logic                m1_req_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                m1_ack_o,
   output logic                m1_err_o,
   output logic                s_ce_o,
   output logic                s_we_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [DATA_W/8-1:0] s_sel_o,
   input  logic [DATA_W-1:0]   s_rdata_i,
   input  logic                s_ack_i,
   output logic                stall_req_o
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t              r_state;
   owner_t              r_owner;
   owner_t              r_last;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_s_ce;
   logic                r_s_we;
   logic [ADDR_W-1:0]   r_s_addr;
   logic [DATA_W-1:0]   r_s_wdata;
   logic [SEL_W-1:0]    r_s_sel;
   logic [DATA_W-1:0]   r_m0_rdata;
   logic [DATA_W-1:0]   r_m1_rdata;
   logic                r_m0_ack;
   logic                r_m0_err;
   logic                r_m1_ack;
   logic                r_m1_err;

   logic                w_gnt_valid;
   owner_t              w_gnt;
   logic                w_timeout;

   rr_arbiter u_rr (
      .i_req0  (m0_req_i),
      .i_req1  (m1_req_i),
      .i_last  (r_last),
      .o_valid (w_gnt_valid),
      .o_gnt   (w_gnt)
   );

   assign w_timeout = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_owner    <= OWN_M0;
         r_last     <= OWN_M1;
         r_cnt      <= '0;
         r_s_ce     <= 1'b0;
         r_s_we     <= 1'b0;
         r_s_addr   <= '0;
         r_s_wdata  <= '0;
         r_s_sel    <= '0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
         r_m0_ack   <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m1_ack   <= 1'b0;
         r_m1_err   <= 1'b0;
      end else begin
         r_m0_ack <= 1'b0;
         r_m0_err <= 1'b0;
         r_m1_ack <= 1'b0;
         r_m1_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_owner <= w_gnt;
                  r_last  <= w_gnt;
                  r_cnt   <= '0;
                  r_s_ce  <= 1'b1;
                  if (w_gnt == OWN_M0) begin
                     r_s_we    <= m0_we_i;
                     r_s_addr  <= m0_addr_i;
                     r_s_wdata <= m0_wdata_i;
                     r_s_sel   <= m0_sel_i;
                  end else begin
                     r_s_we    <= 1'b0;
                     r_s_addr  <= m1_addr_i;
                     r_s_wdata <= '0;
                     r_s_sel   <= '1;
                  end
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // A memory ack on the last allowed cycle still wins over the abort.
               if (s_ack_i || w_timeout) begin
                  r_s_ce    <= 1'b0;
                  r_s_we    <= 1'b0;
                  r_s_addr  <= '0;
                  r_s_wdata <= '0;
                  r_s_sel   <= '0;
                  r_state   <= ST_DONE;
                  if (r_owner == OWN_M0) begin
                     r_m0_rdata <= s_ack_i ? s_rdata_i : '0;
                     r_m0_ack   <= s_ack_i;
                     r_m0_err   <= ~s_ack_i;
                  end else begin
                     r_m1_rdata <= s_ack_i ? s_rdata_i : '0;
                     r_m1_ack   <= s_ack_i;
                     r_m1_err   <= ~s_ack_i;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s_ce_o      = r_s_ce;
   assign s_we_o      = r_s_we;
   assign s_addr_o    = r_s_addr;
   assign s_wdata_o   = r_s_wdata;
   assign s_sel_o     = r_s_sel;
   assign m0_rdata_o  = r_m0_rdata;
   assign m1_rdata_o  = r_m1_rdata;
   assign m0_ack_o    = r_m0_ack;
   assign m0_err_o    = r_m0_err;
   assign m1_ack_o    = r_m1_ack;
   assign m1_err_o    = r_m1_err;

   assign stall_req_o = (m0_req_i & ~r_m0_ack & ~r_m0_err) |
                        (m1_req_i & ~r_m1_ack & ~r_m1_err);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req_i, m0_we_i;
   logic [31:0] m0_addr_i, m0_wdata_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_rdata_o;
   logic        m0_ack_o, m0_err_o;
   logic        m1_req_i;
   logic [31:0] m1_addr_i;
   logic [31:0] m1_rdata_o;
   logic        m1_ack_o, m1_err_o;
   logic        s_ce_o, s_we_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_rdata_i;
   logic        s_ack_i;
   logic        stall_req_o;

   typedef struct {
      logic        mst;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   mem_wait = 0;
   bit   mem_never = 0;
   bit   mem_force_ack = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i), .m0_rdata_o(m0_rdata_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_rdata_o(m1_rdata_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
      .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o), .s_rdata_i(s_rdata_i),
      .s_ack_i(s_ack_i), .stall_req_o(stall_req_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h4) return 32'h3401_1100;
      return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
   endfunction

   // Memory: acks after mem_wait BUSY cycles, optionally never, optionally stray acks while idle.
   initial begin
      int busy_cnt;
      busy_cnt = 0;
      s_ack_i = 1'b0;
      s_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (s_ce_o) begin
            if (!mem_never && busy_cnt == mem_wait) begin
               s_ack_i = 1'b1;
               s_rdata_i = mem_model(s_addr_o);
            end else begin
               s_ack_i = 1'b0;
               s_rdata_i = $urandom;
            end
            busy_cnt++;
         end else begin
            s_ack_i = mem_force_ack;
            s_rdata_i = $urandom;
            busy_cnt = 0;
         end
      end
   end

   initial begin
      exp_t e;
      logic [3:0] got, want;
      logic [31:0] rd;
      forever begin
         @(negedge clk);
         got = {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
         if (got != 4'b0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_completion: got %b, required none", got);
            end else begin
               e = sb.pop_front();
               want = e.mst ? {2'b00, ~e.err, e.err} : {~e.err, e.err, 2'b00};
               if (got !== want) begin
                  errors++;
                  $display("FAIL completion_kind: got %b, required %b", got, want);
               end
               checks++;
               rd = e.mst ? m1_rdata_o : m0_rdata_o;
               if (rd !== e.rdata) begin
                  errors++;
                  $display("FAIL completion_rdata: got %h, required %h", rd, e.rdata);
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      m0_we_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_sel_i = '0; m1_addr_i = '0;
      rst = 1'b1;
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ce_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o} !== 70'b0) begin
         errors++;
         $display("FAIL reset_s_bus: got %b/%h/%h/%h, required zeros", s_ce_o, s_addr_o, s_wdata_o, s_sel_o);
      end
      checks++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, stall_req_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %b, required 00000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, stall_req_o});
      end
      checks++;
      if ({m0_rdata_o, m1_rdata_o} !== 64'b0) begin
         errors++;
         $display("FAIL reset_rdata: got %h %h, required 0", m0_rdata_o, m1_rdata_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      m1_addr_i = 32'h4; m1_req_i = 1'b1;
      sb.push_back('{1'b1, 1'b0, 32'h3401_1100});
      #1;
      checks++;
      if (stall_req_o !== 1'b1) begin
         errors++; $display("FAIL fetch_stall_n: got %b, required 1", stall_req_o);
      end
      @(negedge clk);
      checks++;
      if ({s_ce_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o, stall_req_o} !== {1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1}) begin
         errors++;
         $display("FAIL fetch_bus: got ce=%b we=%b a=%h d=%h s=%h st=%b, required 1 0 4 0 f 1", s_ce_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o, stall_req_o);
      end
      @(negedge clk);
      checks++;
      if ({m1_ack_o, stall_req_o, s_ce_o} !== 3'b100) begin
         errors++; $display("FAIL fetch_ack_n2: got ack/stall/ce %b%b%b, required 100", m1_ack_o, stall_req_o, s_ce_o);
      end
      m1_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({m1_ack_o, m1_rdata_o} !== {1'b0, 32'h3401_1100}) begin
         errors++; $display("FAIL fetch_hold: got ack=%b rdata=%h, required 0 34011100", m1_ack_o, m1_rdata_o);
      end
   endtask

   task automatic test_store();
      int busy;
      bit done;
      busy = 0; done = 0;
      mem_wait = 3;
      @(negedge clk);
      m0_we_i = 1'b1; m0_addr_i = 32'h100; m0_wdata_i = 32'hDEAD_BEEF; m0_sel_i = 4'h3; m0_req_i = 1'b1;
      sb.push_back('{1'b0, 1'b0, mem_model(32'h100)});
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m0_ack_o) begin
            done = 1; m0_req_i = 1'b0; mem_force_ack = 1'b1;
            break;
         end
         if (s_ce_o) begin
            checks++;
            if ({s_we_o, s_addr_o, s_wdata_o, s_sel_o} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3}) begin
               errors++;
               $display("FAIL store_stable: got we=%b a=%h d=%h s=%h, required 1 100 deadbeef 3", s_we_o, s_addr_o, s_wdata_o, s_sel_o);
            end
            busy++;
            m0_we_i = 1'b0; m0_addr_i = $urandom; m0_wdata_i = $urandom; m0_sel_i = 4'($urandom);
         end
      end
      checks++;
      if (!done || busy != 4) begin
         errors++; $display("FAIL store_busy_cycles: got done=%0d busy=%0d, required 1 4", done, busy);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_ce_o} !== 5'b0) begin
            errors++; $display("FAIL late_ack_ignored: got %b, required 00000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_ce_o});
         end
      end
      mem_force_ack = 1'b0;
      mem_wait = 0;
   endtask

   task automatic test_timeout();
      int ce_cnt;
      bit done;
      ce_cnt = 0; done = 0;
      mem_never = 1;
      @(negedge clk);
      m0_we_i = 1'b0; m0_addr_i = 32'h200; m0_sel_i = 4'hF; m0_req_i = 1'b1;
      sb.push_back('{1'b0, 1'b1, 32'h0});
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m0_err_o) begin
            done = 1; m0_req_i = 1'b0;
            break;
         end
         if (s_ce_o) ce_cnt++;
      end
      checks++;
      if (!done || ce_cnt != 16) begin
         errors++; $display("FAIL timeout_ce_cycles: got done=%0d ce=%0d, required 1 16", done, ce_cnt);
      end
      mem_never = 0;
      @(negedge clk);
      checks++;
      if ({m0_err_o, s_ce_o, m0_rdata_o} !== 34'b0) begin
         errors++; $display("FAIL timeout_after: got err=%b ce=%b rdata=%h, required 0 0 0", m0_err_o, s_ce_o, m0_rdata_o);
      end
      m1_addr_i = 32'h300; m1_req_i = 1'b1;
      sb.push_back('{1'b1, 1'b0, mem_model(32'h300)});
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (m1_ack_o !== 1'b1) begin
         errors++; $display("FAIL timeout_then_idle: got m1_ack=%b, required 1", m1_ack_o);
      end
      m1_req_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      int stamps[4];
      int n, t0;
      n = 0;
      do_reset();
      @(negedge clk);
      m0_we_i = 1'b0; m0_addr_i = 32'h40; m0_sel_i = 4'hF; m1_addr_i = 32'h80;
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) sb.push_back('{1'b0, 1'b0, mem_model(32'h40)});
         else            sb.push_back('{1'b1, 1'b0, mem_model(32'h80)});
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (m0_ack_o || m1_ack_o) begin
            stamps[n] = cyc; n++;
            if (n == 4) begin
               m0_req_i = 1'b0; m1_req_i = 1'b0;
               break;
            end
         end
      end
      checks++;
      if (n != 4) begin
         errors++; $display("FAIL rr_count: got %0d completions, required 4", n);
      end else begin
         checks++;
         if (stamps[0] - t0 != 2) begin
            errors++; $display("FAIL rr_first_latency: got %0d, required 2", stamps[0] - t0);
         end
         for (int k = 1; k < 4; k++) begin
            checks++;
            if (stamps[k] - stamps[k-1] != 3) begin
               errors++; $display("FAIL rr_spacing_%0d: got %0d, required 3", k, stamps[k] - stamps[k-1]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({s_ce_o, m0_rdata_o, m1_rdata_o} !== {1'b0, mem_model(32'h40), mem_model(32'h80)}) begin
         errors++; $display("FAIL rr_rdata_hold: got ce=%b %h %h, required 0 %h %h", s_ce_o, m0_rdata_o, m1_rdata_o, mem_model(32'h40), mem_model(32'h80));
      end
   endtask

   task automatic test_reset_busy();
      mem_never = 1;
      @(negedge clk);
      m0_we_i = 1'b1; m0_addr_i = 32'h500; m0_wdata_i = 32'h1234_5678; m0_sel_i = 4'hF; m0_req_i = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ce_o !== 1'b1) begin
         errors++; $display("FAIL rbusy_cycle1: got ce=%b, required 1", s_ce_o);
      end
      @(posedge clk);
      #2;
      m0_req_i = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({s_ce_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o, m0_rdata_o, m1_rdata_o} !== 134'b0 ||
          {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, stall_req_o} !== 5'b0) begin
         errors++; $display("FAIL rbusy_outputs: got ce=%b a=%h r0=%h r1=%h p=%b, required all 0", s_ce_o, s_addr_o, m0_rdata_o, m1_rdata_o, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, stall_req_o});
      end
      @(negedge clk);
      rst = 1'b0;
      mem_never = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({m0_ack_o, m0_err_o, s_ce_o} !== 3'b0) begin
            errors++; $display("FAIL rbusy_silent: got %b, required 000", {m0_ack_o, m0_err_o, s_ce_o});
         end
      end
      m1_addr_i = 32'h4; m1_req_i = 1'b1;
      sb.push_back('{1'b1, 1'b0, 32'h3401_1100});
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (m1_ack_o !== 1'b1) begin
         errors++; $display("FAIL rbusy_refetch: got m1_ack=%b, required 1", m1_ack_o);
      end
      m1_req_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_timeout();
      test_back_to_back();
      test_reset_busy();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 16, maximum BUSY cycles before abort (minimum 2).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  m0_req_i  in  1  data master (mem stage) request, held until m0 ack/err
  m0_we_i  in  1  data master write enable
  m0_addr_i  in  ADDR_W  data master address
  m0_wdata_i  in  DATA_W  data master write data
  m0_sel_i  in  DATA_W/8  data master byte select
  m0_rdata_o  out  DATA_W  data master read data, valid with m0_ack_o
  m0_ack_o  out  1  data master completion pulse
  m0_err_o  out  1  data master timeout pulse
  m1_req_i  in  1  fetch master request, held until m1 ack/err
  m1_addr_i  in  ADDR_W  fetch address (read-only, sel all ones)
  m1_rdata_o  out  DATA_W  fetched instruction, valid with m1_ack_o
  m1_ack_o  out  1  fetch completion pulse
  m1_err_o  out  1  fetch timeout pulse
  s_ce_o  out  1  shared memory chip enable
  s_we_o  out  1  shared memory write enable
  s_addr_o  out  ADDR_W  shared memory address
  s_wdata_o  out  DATA_W  shared memory write data
  s_sel_o  out  DATA_W/8  shared memory byte select
  s_rdata_i  in  DATA_W  shared memory read data, valid with s_ack_i
  s_ack_i  in  1  shared memory completion
  stall_req_o  out  1  pipeline stall request

Function
REQ-003 FSM SHALL have states IDLE, BUSY, DONE.
REQ-004 IDLE: one requester -> grant it; both -> grant the master not granted last (round-robin); none -> stay IDLE.
REQ-005 On grant, SHALL register we/addr/wdata/sel (m1: we=0, sel=all ones), record grant owner, update last-grant, clear timeout counter, enter BUSY next cycle.
REQ-006 BUSY: s_ce_o=1 and s_we/addr/wdata/sel driven from registered values only; master inputs changing during BUSY SHALL have no effect.
REQ-007 BUSY with s_ack_i=1: register s_rdata_i into owner's rdata, enter DONE with owner ack pending.
REQ-008 BUSY without s_ack_i: increment counter; counter reaching TIMEOUT-1 -> enter DONE with owner err pending, owner rdata=0.
REQ-009 DONE: exactly one of owner's ack_o/err_o high for exactly one cycle; s_ce_o=0; next state IDLE unconditionally.
REQ-010 Requests SHALL not be sampled in DONE; a master may re-request in the cycle after its ack, arbitrated in IDLE.
REQ-011 s_ack_i in IDLE or DONE SHALL be ignored.
REQ-012 Zero-wait memory: req cycle N -> s_ce_o cycle N+1 -> ack_o cycle N+2; next grant earliest N+3.
REQ-013 stall_req_o SHALL be combinational: (m0_req_i and not m0_ack_o and not m0_err_o) or (same for m1).
REQ-014 s_* outputs SHALL be 0 whenever s_ce_o=0; rdata_o holds last value except when cleared by err or reset.

Reset
REQ-015 rst=1 SHALL asynchronously force state IDLE, counter 0, all outputs 0, last-grant=m1 (first tie to m0).
REQ-016 Reset mid-BUSY SHALL abort silently: no ack/err, s_ce_o low immediately; masters re-request after reset.

Structure
REQ-017 Shared package SHALL hold state encodings, default widths, TIMEOUT default, grant-owner encoding.
REQ-018 One sub-module rr_arbiter SHALL compute grant from two requests and last-grant; FSM, counter, datapath registers stay in mem_arbiter.

Verification
REQ-019 Single fetch: m1_req, addr 0x0000_0004, s_ack_i same cycle as s_ce_o, rdata 0x3401_1100 -> m1_ack_o cycle N+2, m1_rdata_o=0x3401_1100, stall_req_o high cycles N..N+1.
REQ-020 Simultaneous after reset: both req -> m0 granted first, m1 next; both held again -> alternating order m0,m1,m0,m1.
REQ-021 Store: m0 we=1, addr 0x100, wdata 0xDEAD_BEEF, sel 0x3, ack after 3 wait cycles -> s_* stable all BUSY cycles, m0_ack_o single pulse.
REQ-022 Timeout: TIMEOUT=16, s_ack_i never -> s_ce_o 16 cycles, m0_err_o one pulse, m0_rdata_o=0, FSM IDLE after.
REQ-023 Reset in BUSY cycle 2 -> all outputs 0 same cycle, no ack/err; post-reset m1 request completes normally.
REQ-024 Late s_ack_i in DONE/IDLE and master input changes during BUSY -> no extra ack, s_* unchanged.
